tft_layer_scheduler: RTL

//  Generates the per-layer request strobes and window-local x/y coordinates for the TFT

---
 rtl/tft_layer_pkg.sv | 34 +++
 rtl/tft_layer_scheduler_win_hit.sv | 29 ++
 rtl/tft_layer_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tft_layer_pkg.sv
// Shared constants for the TFT layer scheduler and display mux.
// Layer indices, config field codes, default windows and colours.
package tft_layer_pkg;
  localparam int NL = 4;

  localparam int L_VENENO   = 0;
  localparam int L_XIAOFANG = 1;
  localparam int L_NUM      = 2;
  localparam int L_IMAGE    = 3;

  localparam logic [1:0] F_X0 = 2'd0;
  localparam logic [1:0] F_Y0 = 2'd1;
  localparam logic [1:0] F_W  = 2'd2;
  localparam logic [1:0] F_H  = 2'd3;

  typedef struct packed {
    int x0;
    int y0;
    int w;
    int h;
  } win_t;

  // The image layer starts disabled (zero size) until software places it.
  localparam win_t DEF_WIN [NL] = '{
    '{x0: 10,  y0: 10, w: 48, h: 16},
    '{x0: 100, y0: 10, w: 48, h: 16},
    '{x0: 400, y0: 40, w: 16, h: 24},
    '{x0: 0,   y0: 0,  w: 0,  h: 0}
  };

  localparam logic [15:0] C_BLACK = 16'h0000;
  localparam logic [15:0] C_WHITE = 16'hFFFF;
  localparam logic [15:0] C_BG    = 16'h001F;
endpackage

// File: rtl/tft_layer_scheduler_win_hit.sv
// Window hit test and window-local coordinates for one layer.
// End coordinates are formed one bit wider so windows past 2^HW clip instead of wrapping.
module tft_win_hit #(
  parameter int HW = 11
) (
  input  logic          de,
  input  logic [HW-1:0] hcount,
  input  logic [HW-1:0] vcount,
  input  logic [HW-1:0] x0,
  input  logic [HW-1:0] y0,
  input  logic [HW-1:0] w,
  input  logic [HW-1:0] h,
  output logic          hit,
  output logic [HW-1:0] lx,
  output logic [HW-1:0] ly
);
  logic [HW:0] x_end;
  logic [HW:0] y_end;

  assign x_end = {1'b0, x0} + {1'b0, w};
  assign y_end = {1'b0, y0} + {1'b0, h};

  assign hit = de && (w != '0) && (h != '0) &&
               (hcount >= x0) && ({1'b0, hcount} < x_end) &&
               (vcount >= y0) && ({1'b0, vcount} < y_end);

  assign lx = hcount - x0;
  assign ly = vcount - y0;
endmodule

// File: rtl/tft_layer_scheduler.sv
// Per-layer request strobes and local coordinates for the TFT mux, with frame-aligned
// double-buffered window config and a frame-paced 0..9 digit sequencer.
module tft_layer_scheduler
  import tft_layer_pkg::*;
#(
  parameter int HW          = 11,
  parameter int FRAMES_STEP = 30
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic          de,
  input  logic [HW-1:0] hcount,
  input  logic [HW-1:0] vcount,
  input  logic          frame_start,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_layer,
  input  logic [1:0]    cfg_field,
  input  logic [HW-1:0] cfg_data,
  output logic [3:0]    addr_req,
  output logic [HW-1:0] lx,
  output logic [HW-1:0] ly,
  output logic [3:0]    pix_req,
  output logic [3:0]    digit,
  output logic          commit
);
  localparam int FCW = (FRAMES_STEP > 1) ? $clog2(FRAMES_STEP) : 1;

  logic [HW-1:0] sh_x0 [NL];
  logic [HW-1:0] sh_y0 [NL];
  logic [HW-1:0] sh_w  [NL];
  logic [HW-1:0] sh_h  [NL];
  logic [HW-1:0] act_x0 [NL];
  logic [HW-1:0] act_y0 [NL];
  logic [HW-1:0] act_w  [NL];
  logic [HW-1:0] act_h  [NL];

  logic [NL-1:0] hit;
  logic [HW-1:0] hit_lx [NL];
  logic [HW-1:0] hit_ly [NL];

  logic [3:0]    win_req;
  logic [HW-1:0] win_lx;
  logic [HW-1:0] win_ly;
  logic [FCW-1:0] frame_cnt;

  // Handshake: a config write transfers on any clk_vga edge where cfg_valid && cfg_ready;
  // cfg_ready drops only during the frame_start cycle, when shadow is being copied.
  assign cfg_ready = ~frame_start;

  for (genvar i = 0; i < NL; i++) begin : g_win
    tft_win_hit #(.HW(HW)) u_hit (
      .de     (de),
      .hcount (hcount),
      .vcount (vcount),
      .x0     (act_x0[i]),
      .y0     (act_y0[i]),
      .w      (act_w[i]),
      .h      (act_h[i]),
      .hit    (hit[i]),
      .lx     (hit_lx[i]),
      .ly     (hit_ly[i])
    );
  end

  // Ascending scan so the highest-numbered hitting layer wins.
  always_comb begin
    win_req = '0;
    win_lx  = '0;
    win_ly  = '0;
    for (int i = 0; i < NL; i++) begin
      if (hit[i]) begin
        win_req    = '0;
        win_req[i] = 1'b1;
        win_lx     = hit_lx[i];
        win_ly     = hit_ly[i];
      end
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        sh_x0[i]  <= HW'(DEF_WIN[i].x0);
        sh_y0[i]  <= HW'(DEF_WIN[i].y0);
        sh_w[i]   <= HW'(DEF_WIN[i].w);
        sh_h[i]   <= HW'(DEF_WIN[i].h);
        act_x0[i] <= HW'(DEF_WIN[i].x0);
        act_y0[i] <= HW'(DEF_WIN[i].y0);
        act_w[i]  <= HW'(DEF_WIN[i].w);
        act_h[i]  <= HW'(DEF_WIN[i].h);
      end
    end else begin
      if (cfg_valid && cfg_ready) begin
        case (cfg_field)
          F_X0:    sh_x0[cfg_layer] <= cfg_data;
          F_Y0:    sh_y0[cfg_layer] <= cfg_data;
          F_W:     sh_w[cfg_layer]  <= cfg_data;
          default: sh_h[cfg_layer]  <= cfg_data;
        endcase
      end
      if (frame_start) begin
        for (int i = 0; i < NL; i++) begin
          act_x0[i] <= sh_x0[i];
          act_y0[i] <= sh_y0[i];
          act_w[i]  <= sh_w[i];
          act_h[i]  <= sh_h[i];
        end
      end
    end
  end

  // Stage A feeds ROM addressing; stage B lines up with the 1-cycle ROM data.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      addr_req <= '0;
      lx       <= '0;
      ly       <= '0;
      pix_req  <= '0;
      commit   <= 1'b0;
    end else begin
      addr_req <= win_req;
      lx       <= win_lx;
      ly       <= win_ly;
      pix_req  <= addr_req;
      commit   <= frame_start;
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      digit     <= '0;
    end else if (frame_start) begin
      if (frame_cnt == FCW'(FRAMES_STEP - 1)) begin
        frame_cnt <= '0;
        digit     <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule
